// File: rtl/mode_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : mode_arbiter_pkg
// Purpose  : Shared constants, state encoding and helpers for the mode arbiter
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mode_arbiter_pkg;

  // Note code 0 means rest/silence on the buzzer path
  localparam int c_NOTE_REST = 0;

  // Default widths and timing for the three-source piano build
  localparam int c_DEF_NUM_SRC       = 3;
  localparam int c_DEF_NOTE_W        = 4;
  localparam int c_DEF_LED_W         = 7;
  localparam int c_DEF_OCT_W         = 2;
  localparam int c_DEF_NUM_W         = 4;
  localparam int c_DEF_OCT_DEFAULT   = 1;
  localparam int c_DEF_STABLE_CYCLES = 16;
  localparam int c_DEF_MUTE_CYCLES   = 1000;

  // Arbiter states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_MUTE   = 2'd2,
    ST_PLAY   = 2'd3
  } arb_state_t;

  // Width of a counter that must hold 0..max_val; never narrower than 1 bit
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mode_arbiter_onehot_settle.sv
//------------------------------------------------------------------------------
// Module   : onehot_settle
// Purpose  : One-hot validity check, candidate register and stability counter
//            producing an accept strobe once a mode has held long enough
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module onehot_settle
  import mode_arbiter_pkg::*;
#(
  parameter int NUM_SRC       = c_DEF_NUM_SRC,
  parameter int STABLE_CYCLES = c_DEF_STABLE_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] mode,
  input  logic               arm,
  output logic               mode_valid,
  output logic               mode_changed,
  output logic [NUM_SRC-1:0] candidate,
  output logic               accept
);

  localparam int              c_CW       = cnt_width(STABLE_CYCLES);
  localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(STABLE_CYCLES);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(STABLE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

  logic [NUM_SRC-1:0] r_cand;
  logic [c_CW-1:0]    r_cnt;

  assign mode_valid   = $onehot(mode);
  assign mode_changed = (mode != r_cand);
  assign candidate    = r_cand;
  // The edge that would bring the count to STABLE_CYCLES is the accepting edge;
  // any mode change on that same edge suppresses acceptance.
  assign accept       = arm && !mode_changed && $onehot(r_cand) && (r_cnt >= c_CNT_LAST);

  // Track the last sampled mode and how many consecutive edges it has held
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (mode_changed) begin
      r_cand <= mode;
      r_cnt  <= mode_valid ? c_CNT_ONE : '0;
    end else if (r_cnt != c_CNT_MAX) begin
      r_cnt  <= r_cnt + c_CNT_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mode_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mode_arbiter
// Purpose  : One-hot mode selection of note sources with settle, silent gap on
//            switch, restart pulses and registered outputs to the drivers
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mode_arbiter
  import mode_arbiter_pkg::*;
#(
  parameter int NUM_SRC       = c_DEF_NUM_SRC,
  parameter int NOTE_W        = c_DEF_NOTE_W,
  parameter int LED_W         = c_DEF_LED_W,
  parameter int OCT_W         = c_DEF_OCT_W,
  parameter int NUM_W         = c_DEF_NUM_W,
  parameter int OCT_DEFAULT   = c_DEF_OCT_DEFAULT,
  parameter int STABLE_CYCLES = c_DEF_STABLE_CYCLES,
  parameter int MUTE_CYCLES   = c_DEF_MUTE_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        mode,
  input  logic [NUM_SRC*NOTE_W-1:0] src_note,
  input  logic [NUM_SRC*LED_W-1:0]  src_led,
  input  logic [NUM_SRC*OCT_W-1:0]  src_oct,
  input  logic [NUM_SRC*NUM_W-1:0]  src_num,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NOTE_W-1:0]         note_out,
  output logic [LED_W-1:0]          led_out,
  output logic [OCT_W-1:0]          octave_out,
  output logic [NUM_W-1:0]          num_out,
  output logic [NUM_SRC-1:0]        active_src,
  output logic                      muting,
  output logic [NUM_SRC-1:0]        src_restart
);

  localparam int                c_MW        = cnt_width(MUTE_CYCLES);
  localparam logic [c_MW-1:0]   c_MUTE_LAST = c_MW'((MUTE_CYCLES > 0) ? MUTE_CYCLES - 1 : 0);
  localparam logic [c_MW-1:0]   c_MUTE_ONE  = c_MW'(1);
  localparam logic [OCT_W-1:0]  c_OCT_DEF   = OCT_W'(OCT_DEFAULT);
  localparam logic [NOTE_W-1:0] c_REST      = NOTE_W'(c_NOTE_REST);

  arb_state_t         r_state;
  logic [c_MW-1:0]    r_mute_cnt;

  logic               w_mode_valid;
  logic               w_mode_changed;
  logic [NUM_SRC-1:0] w_candidate;
  logic               w_accept;

  logic [NOTE_W-1:0]  w_sel_note;
  logic [LED_W-1:0]   w_sel_led;
  logic [OCT_W-1:0]   w_sel_oct;
  logic [NUM_W-1:0]   w_sel_num;
  logic               w_sel_valid;

  onehot_settle #(
    .NUM_SRC       (NUM_SRC),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_settle (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .arm          (r_state == ST_SETTLE),
    .mode_valid   (w_mode_valid),
    .mode_changed (w_mode_changed),
    .candidate    (w_candidate),
    .accept       (w_accept)
  );

  // OR-mux of the accepted source's fields; active_src is one-hot or zero
  always_comb begin
    w_sel_note  = '0;
    w_sel_led   = '0;
    w_sel_oct   = '0;
    w_sel_num   = '0;
    w_sel_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active_src[i]) begin
        w_sel_note  = w_sel_note | src_note[i*NOTE_W +: NOTE_W];
        w_sel_led   = w_sel_led  | src_led[i*LED_W +: LED_W];
        w_sel_oct   = w_sel_oct  | src_oct[i*OCT_W +: OCT_W];
        w_sel_num   = w_sel_num  | src_num[i*NUM_W +: NUM_W];
        w_sel_valid = w_sel_valid | src_valid[i];
      end
    end
  end

  // Arbiter FSM; every output is registered and reflects the state just left
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mute_cnt  <= '0;
      note_out    <= c_REST;
      led_out     <= '0;
      octave_out  <= c_OCT_DEF;
      num_out     <= '0;
      active_src  <= '0;
      muting      <= 1'b0;
      src_restart <= '0;
    end else begin
      src_restart <= '0;
      case (r_state)
        ST_IDLE: begin
          note_out   <= c_REST;
          led_out    <= '0;
          octave_out <= c_OCT_DEF;
          num_out    <= '0;
          active_src <= '0;
          if (w_mode_valid) begin
            r_state <= ST_SETTLE;
            muting  <= 1'b1;
          end else begin
            muting  <= 1'b0;
          end
        end

        ST_SETTLE: begin
          note_out   <= c_REST;
          led_out    <= '0;
          octave_out <= c_OCT_DEF;
          if (w_mode_changed) begin
            // A valid change just restarts the count inside the settle block
            if (!w_mode_valid) begin
              r_state    <= ST_IDLE;
              active_src <= '0;
              num_out    <= '0;
              muting     <= 1'b0;
            end
          end else if (w_accept) begin
            active_src  <= w_candidate;
            src_restart <= w_candidate;
            r_mute_cnt  <= '0;
            if (MUTE_CYCLES == 0) begin
              r_state <= ST_PLAY;
              muting  <= 1'b0;
            end else begin
              r_state <= ST_MUTE;
              muting  <= 1'b1;
            end
          end
        end

        ST_MUTE, ST_PLAY: begin
          if (w_mode_changed) begin
            // Silence at once; the old source stays reported until re-settled
            note_out   <= c_REST;
            led_out    <= '0;
            octave_out <= c_OCT_DEF;
            if (w_mode_valid) begin
              r_state <= ST_SETTLE;
              muting  <= 1'b1;
            end else begin
              r_state    <= ST_IDLE;
              active_src <= '0;
              num_out    <= '0;
              muting     <= 1'b0;
            end
          end else if (r_state == ST_MUTE) begin
            note_out   <= c_REST;
            led_out    <= '0;
            octave_out <= c_OCT_DEF;
            num_out    <= w_sel_num;
            if (r_mute_cnt >= c_MUTE_LAST) begin
              r_state <= ST_PLAY;
              muting  <= 1'b0;
            end else begin
              r_mute_cnt <= r_mute_cnt + c_MUTE_ONE;
            end
          end else begin
            muting     <= 1'b0;
            note_out   <= w_sel_valid ? w_sel_note : c_REST;
            led_out    <= w_sel_valid ? w_sel_led : '0;
            octave_out <= w_sel_oct;
            num_out    <= w_sel_num;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mode_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mode_arbiter
// Purpose  : Self-checking bench for mode_arbiter (STABLE=4, MUTE=8 and MUTE=0)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mode_arbiter;

  localparam int NS = 3;
  localparam int NW = 4;
  localparam int LW = 7;
  localparam int OW = 2;
  localparam int UW = 4;

  typedef struct packed {
    logic [NW-1:0] note;
    logic [LW-1:0] led;
    logic [OW-1:0] oct;
    logic [UW-1:0] num;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, rst0;
  logic [NS-1:0]    mode, mode0;
  logic [NS*NW-1:0] src_note;
  logic [NS*LW-1:0] src_led;
  logic [NS*OW-1:0] src_oct;
  logic [NS*UW-1:0] src_num;
  logic [NS-1:0]    src_valid;

  logic [NW-1:0] note_out, note0;
  logic [LW-1:0] led_out, led0;
  logic [OW-1:0] octave_out, oct0;
  logic [UW-1:0] num_out, num0;
  logic [NS-1:0] active_src, active0;
  logic          muting, muting0;
  logic [NS-1:0] src_restart, restart0;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  mode_arbiter #(
    .NUM_SRC(NS), .NOTE_W(NW), .LED_W(LW), .OCT_W(OW), .NUM_W(UW),
    .OCT_DEFAULT(1), .STABLE_CYCLES(4), .MUTE_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .src_note(src_note), .src_led(src_led), .src_oct(src_oct), .src_num(src_num),
    .src_valid(src_valid),
    .note_out(note_out), .led_out(led_out), .octave_out(octave_out), .num_out(num_out),
    .active_src(active_src), .muting(muting), .src_restart(src_restart)
  );

  mode_arbiter #(
    .NUM_SRC(NS), .NOTE_W(NW), .LED_W(LW), .OCT_W(OW), .NUM_W(UW),
    .OCT_DEFAULT(1), .STABLE_CYCLES(4), .MUTE_CYCLES(0)
  ) dut0 (
    .clk(clk), .reset(rst0), .mode(mode0),
    .src_note(src_note), .src_led(src_led), .src_oct(src_oct), .src_num(src_num),
    .src_valid(src_valid),
    .note_out(note0), .led_out(led0), .octave_out(oct0), .num_out(num0),
    .active_src(active0), .muting(muting0), .src_restart(restart0)
  );

  // Pack an output set for whole-vector comparison
  function automatic logic [23:0] pk(input logic [3:0] n, input logic [6:0] l, input logic [1:0] o,
                                     input logic [3:0] u, input logic [2:0] a, input logic m,
                                     input logic [2:0] r);
    return {n, l, o, u, a, m, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [3:0] n, input logic [6:0] l,
                         input logic [1:0] o, input logic [3:0] u);
    src_note[i*NW +: NW] = n;
    src_led[i*LW +: LW]  = l;
    src_oct[i*OW +: OW]  = o;
    src_num[i*UW +: UW]  = u;
  endtask

  // Reset state, first acceptance, silent gap, then 1-cycle-latency follow
  task automatic test_reset();
    logic [23:0] exp_v;
    tick();
    tick();
    exp_v = pk(4'd0, 7'd0, 2'd1, 4'd0, 3'b000, 1'b0, 3'b000);
    total++;
    if (pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart) !== exp_v) begin
      bad++;
      $display("FAIL reset_state: got %h want %h",
               pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart), exp_v);
    end
    reset = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      exp_v = (t == 4) ? pk(4'd0, 7'd0, 2'd1, 4'd0, 3'b010, 1'b1, 3'b010)
                       : pk(4'd0, 7'd0, 2'd1, 4'd0, 3'b000, 1'b1, 3'b000);
      total++;
      if (pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart) !== exp_v) begin
        bad++;
        $display("FAIL settle_cycle%0d: got %h want %h", t,
                 pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart), exp_v);
      end
    end
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_v = pk(4'd0, 7'd0, 2'd1, 4'd9, 3'b010, (t == 8) ? 1'b0 : 1'b1, 3'b000);
      total++;
      if (pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart) !== exp_v) begin
        bad++;
        $display("FAIL mute_cycle%0d: got %h want %h", t,
                 pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart), exp_v);
      end
    end
    tick();
    exp_v = pk(4'd7, 7'h55, 2'd2, 4'd9, 3'b010, 1'b0, 3'b000);
    total++;
    if (pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart) !== exp_v) begin
      bad++;
      $display("FAIL first_play: got %h want %h",
               pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart), exp_v);
    end
  endtask

  // Random source traffic in PLAY; expectations queued when driven
  task automatic test_play_stream();
    exp_t e;
    exp_t got;
    logic v;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < NS; i++)
        set_src(i, 4'($urandom), 7'($urandom), 2'($urandom), 4'($urandom));
      src_valid = 3'($urandom);
      v = src_valid[1];
      e.note = v ? src_note[1*NW +: NW] : 4'd0;
      e.led  = v ? src_led[1*LW +: LW] : 7'd0;
      e.oct  = src_oct[1*OW +: OW];
      e.num  = src_num[1*UW +: UW];
      sb.push_back(e);
      tick();
      e   = sb.pop_front();
      got = {note_out, led_out, octave_out, num_out};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL play_stream%0d: got %h want %h", k, got, e);
      end
    end
  endtask

  // Source 1 invalid: note/led silenced, octave and number still pass
  task automatic test_src_invalid();
    set_src(1, 4'd5, 7'h7f, 2'd3, 4'd4);
    src_valid = 3'b101;
    tick();
    total++;
    if ({note_out, led_out, octave_out, num_out} !== {4'd0, 7'd0, 2'd3, 4'd4}) begin
      bad++;
      $display("FAIL src_invalid: got %h want %h", {note_out, led_out, octave_out, num_out},
               {4'd0, 7'd0, 2'd3, 4'd4});
    end
    src_valid = 3'b111;
  endtask

  // Short glitch to source 0 never accepted; source 1 re-accepted with pulse
  task automatic test_glitch();
    logic [23:0] exp_v;
    set_src(1, 4'd3, 7'h11, 2'd2, 4'd6);
    tick();
    mode = 3'b001;
    for (int t = 1; t <= 2; t++) begin
      tick();
      exp_v = pk(4'd0, 7'd0, 2'd1, 4'd6, 3'b010, 1'b1, 3'b000);
      total++;
      if (pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart) !== exp_v) begin
        bad++;
        $display("FAIL glitch%0d: got %h want %h", t,
                 pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart), exp_v);
      end
    end
    mode = 3'b010;
    for (int t = 1; t <= 4; t++) begin
      tick();
      total++;
      if (src_restart !== ((t == 4) ? 3'b010 : 3'b000) || active_src !== 3'b010 || muting !== 1'b1) begin
        bad++;
        $display("FAIL reaccept%0d: got restart=%b active=%b muting=%b want restart=%b active=010 muting=1",
                 t, src_restart, active_src, muting, (t == 4) ? 3'b010 : 3'b000);
      end
    end
    for (int t = 0; t < 9; t++) tick();
    total++;
    if (note_out !== 4'd3 || muting !== 1'b0) begin
      bad++;
      $display("FAIL glitch_resume: got note=%0d muting=%b want note=3 muting=0", note_out, muting);
    end
  endtask

  // Two-hot mode in PLAY drops straight to IDLE
  task automatic test_invalid_mode();
    logic [23:0] exp_v;
    mode  = 3'b011;
    exp_v = pk(4'd0, 7'd0, 2'd1, 4'd0, 3'b000, 1'b0, 3'b000);
    for (int t = 1; t <= 2; t++) begin
      tick();
      total++;
      if (pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart) !== exp_v) begin
        bad++;
        $display("FAIL invalid_mode%0d: got %h want %h", t,
                 pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart), exp_v);
      end
    end
  endtask

  // Reset during MUTE aborts; no restart pulse afterwards
  task automatic test_reset_in_mute();
    logic [23:0] exp_v;
    mode = 3'b100;
    for (int t = 1; t <= 4; t++) tick();
    total++;
    if (src_restart !== 3'b100) begin
      bad++;
      $display("FAIL accept_src2: got restart=%b want 100", src_restart);
    end
    tick();
    tick();
    reset = 1'b1;
    mode  = 3'b000;
    tick();
    exp_v = pk(4'd0, 7'd0, 2'd1, 4'd0, 3'b000, 1'b0, 3'b000);
    total++;
    if (pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart) !== exp_v) begin
      bad++;
      $display("FAIL reset_in_mute: got %h want %h",
               pk(note_out, led_out, octave_out, num_out, active_src, muting, src_restart), exp_v);
    end
    tick();
    reset = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      total++;
      if (src_restart !== 3'b000 || active_src !== 3'b000 || muting !== 1'b0) begin
        bad++;
        $display("FAIL after_reset%0d: got restart=%b active=%b muting=%b want 000 000 0",
                 t, src_restart, active_src, muting);
      end
    end
  endtask

  // Mode change on the completing edge wins over acceptance
  task automatic test_change_at_complete();
    mode = 3'b001;
    for (int t = 1; t <= 3; t++) tick();
    mode = 3'b100;
    for (int t = 0; t <= 3; t++) begin
      tick();
      total++;
      if (src_restart !== ((t == 3) ? 3'b100 : 3'b000) || active_src !== ((t == 3) ? 3'b100 : 3'b000)) begin
        bad++;
        $display("FAIL change_wins%0d: got restart=%b active=%b want %b", t, src_restart, active_src,
                 (t == 3) ? 3'b100 : 3'b000);
      end
    end
  endtask

  // Zero-length gap: pulse and PLAY on the accepting edge, data next cycle
  task automatic test_no_mute();
    rst0  = 1'b1;
    mode0 = 3'b001;
    src_valid = 3'b111;
    set_src(2, 4'd11, 7'h2a, 2'd3, 4'd2);
    tick();
    tick();
    rst0 = 1'b0;
    for (int t = 1; t <= 4; t++) tick();
    total++;
    if (restart0 !== 3'b001 || muting0 !== 1'b0) begin
      bad++;
      $display("FAIL nomute_first: got restart=%b muting=%b want 001 0", restart0, muting0);
    end
    tick();
    mode0 = 3'b100;
    for (int t = 1; t <= 4; t++) begin
      tick();
      total++;
      if (restart0 !== ((t == 4) ? 3'b100 : 3'b000) || muting0 !== ((t == 4) ? 1'b0 : 1'b1) || note0 !== 4'd0) begin
        bad++;
        $display("FAIL nomute_switch%0d: got restart=%b muting=%b note=%0d", t, restart0, muting0, note0);
      end
    end
    tick();
    total++;
    if (note0 !== 4'd11 || active0 !== 3'b100 || oct0 !== 2'd3) begin
      bad++;
      $display("FAIL nomute_play: got note=%0d active=%b oct=%0d want 11 100 3", note0, active0, oct0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    rst0      = 1'b1;
    mode      = 3'b010;
    mode0     = 3'b000;
    src_note  = '0;
    src_led   = '0;
    src_oct   = '0;
    src_num   = '0;
    src_valid = 3'b111;
    set_src(1, 4'd7, 7'h55, 2'd2, 4'd9);
    test_reset();
    test_play_stream();
    test_src_invalid();
    test_glitch();
    test_invalid_mode();
    test_reset_in_mute();
    test_change_at_complete();
    test_no_mute();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
